imem_fetch_buf: RTL

- Parametrised successor to the core's fixed 64-byte instruction memory.
- Byte-addressable, big-endian instruction store of configurable depth.
- Fetch side uses a valid/ready request/response handshake with a registered output, stall hold, pipeline flush and fault flagging.
- A byte-wide programming port loads the program at run time. The block sits between the PC/IF stage and the IF/ID pipeline register.

---
 rtl/imem_fetch_buf.sv | 124 ++++++++++++
 1 files changed

// File: rtl/imem_fetch_buf.sv
// Purpose : byte-addressable big-endian instruction store with a registered fetch response.
// Latency : one cycle from accepted request to rsp_valid.
// Backpr. : a held response (rsp_valid && !rsp_ready) freezes the outputs and drops req_ready.
//
// Ports:
//   clk, resetn          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready  fetch request handshake, req_addr = byte address
//   rsp_valid/rsp_ready  response handshake; rsp_instr, rsp_addr, rsp_fault are registered
//   flush                discard any held response, block new requests this cycle
//   prog_en/addr/data    byte-wide program load port
//   perf_fetch_cnt,      present only with IMEM_PERF_CNT_EN defined: accepted-fetch and
//   perf_stall_cnt       stalled-cycle counters
module imem_fetch_buf #(
    parameter int          DEPTH_BYTES = 512,
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_fault,
    input  logic              flush,
    input  logic              prog_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data
`ifdef IMEM_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);

    logic [7:0] r_mem [DEPTH_BYTES];

    logic              r_rsp_valid;
    logic [31:0]       r_rsp_instr;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic              r_rsp_fault;

    logic              w_accept;
    logic              w_fault;
    logic              w_prog_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic [31:0]       w_rd_word;

    // Compare in 64 bits so every address bit takes part in the range check.
    assign w_fault = (req_addr[1:0] != 2'b00) ||
                     (64'(req_addr) > 64'(DEPTH_BYTES - 4));
    assign w_prog_in_range = 64'(prog_addr) < 64'(DEPTH_BYTES);

    assign req_ready = !prog_en && !flush && (!r_rsp_valid || rsp_ready);
    assign w_accept  = req_valid && req_ready;

    // Only meaningful when the fetch is in range; faulting fetches select NOP_WORD instead.
    assign w_idx     = req_addr[IDX_W-1:0];
    assign w_rd_word = {r_mem[w_idx],
                        r_mem[w_idx + IDX_W'(1)],
                        r_mem[w_idx + IDX_W'(2)],
                        r_mem[w_idx + IDX_W'(3)]};

    // Storage is deliberately not reset so a loaded program survives a core reset.
    always_ff @(posedge clk) begin
        if (prog_en && w_prog_in_range) begin
            r_mem[prog_addr[IDX_W-1:0]] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= NOP_WORD;
            r_rsp_addr  <= '0;
            r_rsp_fault <= 1'b0;
        end else if (flush) begin
            // rsp_addr is left as-is; only the instruction is squashed to a NOP.
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= NOP_WORD;
            r_rsp_fault <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_addr  <= req_addr;
            r_rsp_fault <= w_fault;
            r_rsp_instr <= w_fault ? NOP_WORD : w_rd_word;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_instr = r_rsp_instr;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_fault = r_rsp_fault;

`ifdef IMEM_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_fetch_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (r_rsp_valid && !rsp_ready) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule
